serial_logic_unit: RTL
======================

// Module: serial_logic_unit
//
// PURPOSE
//   Bit-serial driver for the 1-bit logic slice of the ALU datapath.
//   - Accepts a WIDTH-bit operand pair and an opcode over a valid/ready handshake.
//   - Feeds the operands to the slice one bit per clock, LSB first.
//   - Collects the result bits in a shift register.
//   - Presents the WIDTH-bit result and a zero flag over a second valid/ready handshake.
//
// PARAMETERS
//   WIDTH  8  operand/result width in bits; legal range 2..32
//
// PORTS
//   clk        in   1      system clock, all state on rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      request valid
//   in_ready   out  1      unit can accept a request
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   op         in   2      00 AND, 01 OR, 10 XOR, 11 NOT A (b ignored)
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result
//   result     out  WIDTH  operation result
//   zero       out  1      result == 0; meaningful only while out_valid
//   busy       out  1      high in SHIFT or DONE
//
// BEHAVIOUR
//   - Reset (rst_n low, asynchronous):
//     - state=IDLE; count, shift registers and result all 0.
//     - out_valid=0, zero=0, busy=0, in_ready=1.
//     - No request is accepted while rst_n is low.
//   - FSM states: IDLE, SHIFT, DONE.
//     - in_ready = (state==IDLE).
//     - busy = (state!=IDLE).
//   - IDLE:
//     - On edge with in_valid && in_ready: latch a, b, op; count=0; go SHIFT.
//     - Otherwise stay in IDLE.
//   - SHIFT, each edge:
//     - Compute bit = f(op, a_sh[0], b_sh[0]).
//     - Shift bit into result MSB; shift a_sh and b_sh right by 1.
//     - count++.
//     - After the WIDTH-th SHIFT edge: go DONE and assert out_valid.
//   - Latency: out_valid rises exactly WIDTH edges after the accepting edge.
//   - Result ordering: LSB-first shifting into the MSB leaves result[i] = f(a[i], b[i]) with no reversal.
//   - DONE:
//     - result and zero held stable while out_valid && !out_ready.
//     - On edge with out_ready: out_valid=0; go IDLE.
//     - in_ready rises the following cycle. No same-cycle re-accept.
//     - Throughput: 1 op per WIDTH+2 cycles minimum.
//   - Input changes:
//     - a, b, op changes after acceptance have no effect on the in-flight op.
//     - in_valid while busy is ignored; the request is not queued.
//   - out_ready while out_valid=0 has no effect.
//   - count width = $clog2(WIDTH+1). No wrap inside an op; cleared on accept.
//   - Reset mid-SHIFT or mid-DONE:
//     - Immediate abort; all outputs return to reset values.
//     - The partial result is never presented.
//
// TESTING
//   - AND a=8'hF0 b=8'h3C, out_ready=1 -> out_valid 8 edges after accept, result=8'h30, zero=0, in_ready back after 1 more cycle.
//   - Sweep: OR 8'hA0|8'h05 -> 8'hA5; XOR 8'h5A^8'h5A -> 8'h00, zero=1; NOT a=8'h0F -> 8'hF0.
//   - Backpressure: hold out_ready=0 for 5 cycles in DONE -> result/out_valid stable, in_ready=0, second in_valid ignored.
//   - Busy ignore: present a=8'hFF b=8'hFF op=AND mid-SHIFT -> in-flight op result unchanged, no second result produced.
//   - Reset: assert rst_n=0 at SHIFT count=3 -> out_valid=0, busy=0, in_ready=1 immediately; next op runs with full WIDTH latency.
//   - Operand hold: change a/b/op one cycle after accept -> result matches latched values.

Source files
------------

// File: rtl/serial_logic_unit.sv
// serial_logic_unit: bit-serial driver for a 1-bit logic slice.
//   A WIDTH-bit operand pair and opcode are accepted over a valid/ready
//   handshake. They are fed to the slice LSB first, one bit per clock. The
//   result bits are collected MSB-in, and the result is presented over a
//   second valid/ready handshake.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake (a, b, op)
//   a, b [WIDTH]        operands
//   op [2]              00 AND, 01 OR, 10 XOR, 11 NOT A
//   out_valid/out_ready result handshake (result, zero)
//   result [WIDTH]      operation result
//   zero                result == 0, gated by out_valid
//   busy                unit is shifting or holding a result

// serial_logic_slice: combinational 1-bit logic function.
//   i_op, i_a, i_b -> o_y
module serial_logic_slice (
  input  logic [1:0] i_op,
  input  logic       i_a,
  input  logic       i_b,
  output logic       o_y
);
  always_comb begin
    o_y = 1'b0;
    unique case (i_op)
      2'b00: o_y = i_a & i_b;
      2'b01: o_y = i_a | i_b;
      2'b10: o_y = i_a ^ i_b;
      2'b11: o_y = ~i_a;
      default: o_y = 1'b0;
    endcase
  end
endmodule

module serial_logic_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a_sh, r_b_sh, r_res;
  logic [1:0]       r_op;
  logic [CW-1:0]    r_cnt;
  logic             w_bit, w_accept, w_last;

  serial_logic_slice u_slice (
    .i_op (r_op),
    .i_a  (r_a_sh[0]),
    .i_b  (r_b_sh[0]),
    .o_y  (w_bit)
  );

  assign w_accept = in_valid && (r_state == IDLE);
  // The count reaches WIDTH-1 on the edge before the WIDTH-th shift. That
  // shift edge is therefore the one that moves the FSM to DONE.
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = SHIFT;
      SHIFT:   if (w_last)   w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh <= '0;
      r_b_sh <= '0;
      r_op   <= 2'b00;
      r_cnt  <= '0;
      r_res  <= '0;
    end else if (w_accept) begin
      r_a_sh <= a;
      r_b_sh <= b;
      r_op   <= op;
      r_cnt  <= '0;
      r_res  <= '0;
    end else if (r_state == SHIFT) begin
      // Shifting LSB-first into the MSB leaves bit i in position i after WIDTH shifts.
      r_res  <= {w_bit, r_res[WIDTH-1:1]};
      r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_res;
  assign zero      = out_valid && (r_res == '0);
endmodule
